// File: rtl/id_branch_resolver.sv
// ID-stage branch/jump resolver: decides taken/not-taken from the comparator
// flags, stalls ID until operands are forwarded, and issues a registered
// redirect + one-cycle IF flush that is held until IF acknowledges it.
module id_branch_resolver #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic             id_is_jal,
  input  logic             id_is_jalr,
  input  logic [2:0]       id_funct3,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [2:0]       com_flags,
  input  logic             op_ready,
  input  logic             ex_flush,
  input  logic             if_redirect_ack,
  output logic             id_stall,
  output logic             if_flush,
  output logic             if_redirect_valid,
  output logic [XLEN-1:0]  if_redirect_pc,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    REDIRECT  = 2'd2
  } state_t;

  // Outcome of resolving the instruction currently in ID.
  typedef struct packed {
    logic            dec;      // a decision is taken this cycle
    logic            taken;
    logic            cond;     // conditional branch (counts in br_cnt)
    logic            illegal;  // B-type with reserved funct3
    logic [XLEN-1:0] target;
  } res_t;

  localparam logic [XLEN-1:0]  LSB_CLR = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  res_t   res;
  logic   cf;
  logic   needs_op;
  logic   can_decide;
  logic   br_cond;
  logic   eq, lt, ltu;

  assign eq  = com_flags[0];
  assign lt  = com_flags[1];
  assign ltu = com_flags[2];

  assign cf       = id_valid & (id_is_branch | id_is_jal | id_is_jalr);
  // JAL needs no register operands; it resolves immediately.
  assign needs_op = ~id_is_jal & (id_is_branch | id_is_jalr);
  // ID is consumed in IDLE/WAIT_OPND only; in REDIRECT it holds a flushed bubble.
  assign can_decide = cf & (state != REDIRECT) & (~needs_op | op_ready);

  // Operand-wait stall; deliberately independent of if_redirect_ack.
  assign id_stall = cf & needs_op & ~op_ready & (state != REDIRECT);

  // Condition evaluation by funct3; reserved encodings are never taken.
  always_comb begin
    br_cond = 1'b0;
    case (id_funct3)
      3'b000:  br_cond = eq;
      3'b001:  br_cond = ~eq;
      3'b100:  br_cond = lt;
      3'b101:  br_cond = ~lt;
      3'b110:  br_cond = ltu;
      3'b111:  br_cond = ~ltu;
      default: br_cond = 1'b0;
    endcase
  end

  // Decision and target; jumps take priority over a stray branch flag.
  always_comb begin
    res        = '0;
    res.dec    = can_decide & ~ex_flush;
    res.target = id_pc + id_imm;
    if (id_is_jal) begin
      res.taken = 1'b1;
    end else if (id_is_jalr) begin
      res.taken  = 1'b1;
      res.target = (rs1_data + id_imm) & LSB_CLR;
    end else begin
      res.cond    = 1'b1;
      res.taken   = br_cond;
      res.illegal = (id_funct3[2:1] == 2'b01);
    end
  end

  // Control FSM with registered redirect/flush/illegal outputs and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      if_flush          <= 1'b0;
      if_redirect_valid <= 1'b0;
      if_redirect_pc    <= '0;
      illegal_branch    <= 1'b0;
      br_cnt            <= '0;
      taken_cnt         <= '0;
    end else begin
      if_flush       <= 1'b0;
      illegal_branch <= 1'b0;
      if (ex_flush) begin
        state             <= IDLE;
        if_redirect_valid <= 1'b0;
      end else begin
        case (state)
          IDLE, WAIT_OPND: begin
            if (res.dec) begin
              illegal_branch <= res.illegal;
              if (res.cond)  br_cnt    <= br_cnt + CNT_ONE;
              if (res.taken) taken_cnt <= taken_cnt + CNT_ONE;
              if (res.taken) begin
                if_redirect_pc    <= res.target;
                if_redirect_valid <= 1'b1;
                if_flush          <= 1'b1;
                state             <= REDIRECT;
              end else begin
                state <= IDLE;
              end
            end else if (id_stall) begin
              state <= WAIT_OPND;
            end else begin
              state <= IDLE;
            end
          end
          REDIRECT: begin
            if (if_redirect_ack) begin
              if_redirect_valid <= 1'b0;
              state             <= IDLE;
            end
          end
          default: begin
            state             <= IDLE;
            if_redirect_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_branch_resolver.sv
// Directed bench for id_branch_resolver: a behavioural model is checked on
// every cycle, and hand-computed literals pin the test-plan scenarios.
module tb_id_branch_resolver;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_is_branch, id_is_jal, id_is_jalr;
  logic [2:0]       id_funct3;
  logic [XLEN-1:0]  id_pc, id_imm, rs1_data;
  logic [2:0]       com_flags;
  logic             op_ready, ex_flush, if_redirect_ack;
  logic             id_stall, if_flush, if_redirect_valid, illegal_branch;
  logic [XLEN-1:0]  if_redirect_pc;
  logic [CNT_W-1:0] br_cnt, taken_cnt;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  id_branch_resolver #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_funct3(id_funct3),
    .id_pc(id_pc), .id_imm(id_imm), .rs1_data(rs1_data), .com_flags(com_flags),
    .op_ready(op_ready), .ex_flush(ex_flush), .if_redirect_ack(if_redirect_ack),
    .id_stall(id_stall), .if_flush(if_flush), .if_redirect_valid(if_redirect_valid),
    .if_redirect_pc(if_redirect_pc), .illegal_branch(illegal_branch),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // busy = a redirect is outstanding towards IF.
  bit              m_busy, m_flush, m_ill;
  logic [XLEN-1:0] m_pc;
  int unsigned     m_br, m_tk;

  function automatic bit m_taken(input logic [2:0] f3, input logic [2:0] fl);
    bit e, l, u;
    e = fl[0]; l = fl[1]; u = fl[2];
    if (f3 == 3'd0) return e;
    if (f3 == 3'd1) return !e;
    if (f3 == 3'd4) return l;
    if (f3 == 3'd5) return !l;
    if (f3 == 3'd6) return u;
    if (f3 == 3'd7) return !u;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit cf, tk, br;
    logic [XLEN-1:0] tgt;
    cf = id_valid && (id_is_branch || id_is_jal || id_is_jalr);
    if (!rst_n) begin
      m_busy = 0; m_flush = 0; m_ill = 0; m_pc = '0; m_br = 0; m_tk = 0;
    end else begin
      m_flush = 0; m_ill = 0;
      if (ex_flush) m_busy = 0;
      else if (m_busy) begin
        if (if_redirect_ack) m_busy = 0;
      end else if (cf && (id_is_jal || op_ready)) begin
        br = !id_is_jal && !id_is_jalr;
        tk = !br || m_taken(id_funct3, com_flags);
        tgt = id_is_jalr && !id_is_jal ? ((rs1_data + id_imm) & ~32'd1) : id_pc + id_imm;
        if (br) m_br++;
        if (br && (id_funct3 == 3'd2 || id_funct3 == 3'd3)) m_ill = 1;
        if (tk) begin
          m_tk++; m_busy = 1; m_flush = 1; m_pc = tgt;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("m_stall", id_stall, !m_busy && id_valid && !id_is_jal &&
          (id_is_branch || id_is_jalr) && !op_ready);
      chk("m_flush", if_flush, m_flush);
      chk("m_valid", if_redirect_valid, m_busy);
      if (m_busy) chk("m_pc", if_redirect_pc, m_pc);
      chk("m_illegal", illegal_branch, m_ill);
      chk("m_br_cnt", br_cnt, m_br);
      chk("m_taken_cnt", taken_cnt, m_tk);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    id_valid = 0; id_is_branch = 0; id_is_jal = 0; id_is_jalr = 0;
    id_funct3 = 0; com_flags = 0; op_ready = 0; ex_flush = 0;
  endtask

  task automatic br(input logic [2:0] f3, input logic [2:0] fl, input logic [31:0] pc,
                    input logic [31:0] imm, input logic rdy);
    clr();
    id_valid = 1; id_is_branch = 1; id_funct3 = f3; com_flags = fl;
    id_pc = pc; id_imm = imm; op_ready = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr();
    rst_n = 0; id_pc = 0; id_imm = 0; rs1_data = 0; if_redirect_ack = 0;
    step(); step();
    rst_n = 1; armed = 1;
    chk("rst_valid", if_redirect_valid, 0);
    chk("rst_pc", if_redirect_pc, 0);
    chk("rst_cnt", {br_cnt, taken_cnt}, 0);

    // Taken BEQ, ack tied high: single-cycle redirect.
    if_redirect_ack = 1;
    br(3'b000, 3'b001, 32'h100, 32'h20, 1);
    step(); clr();
    chk("beq_flush", if_flush, 1);
    chk("beq_valid", if_redirect_valid, 1);
    chk("beq_pc", if_redirect_pc, 32'h120);
    chk("beq_cnt", {br_cnt, taken_cnt}, {32'd1, 32'd1});
    step();
    chk("beq_valid_off", if_redirect_valid, 0);
    chk("beq_flush_off", if_flush, 0);

    // BLT not taken, BGEU not taken (ltu set).
    br(3'b100, 3'b000, 32'h200, 32'h40, 1);
    step();
    chk("blt_nt", {if_flush, if_redirect_valid}, 0);
    br(3'b111, 3'b100, 32'h204, 32'h40, 1);
    step(); clr();
    chk("bgeu_nt", {if_flush, if_redirect_valid}, 0);
    chk("bgeu_cnt", {br_cnt, taken_cnt}, {32'd3, 32'd1});

    // JALR with two operand-wait cycles.
    clr(); id_valid = 1; id_is_jalr = 1; rs1_data = 32'h1003; id_imm = 4; op_ready = 0;
    #1 chk("jalr_stall0", id_stall, 1);
    step();
    chk("jalr_stall1", id_stall, 1);
    step();
    op_ready = 1;
    #1 chk("jalr_stall_rel", id_stall, 0);
    step(); clr();
    chk("jalr_pc", if_redirect_pc, 32'h1006);
    chk("jalr_valid", if_redirect_valid, 1);
    step();

    // JAL with wrapping target, no stall.
    clr(); id_valid = 1; id_is_jal = 1; id_pc = 32'hFFFF_FFF0; id_imm = 32'h20;
    #1 chk("jal_nostall", id_stall, 0);
    step(); clr();
    chk("jal_pc", if_redirect_pc, 32'h10);
    chk("jal_cnt", taken_cnt, 3);
    step();

    // Taken BNE with ack held low for three valid cycles.
    if_redirect_ack = 0;
    br(3'b001, 3'b000, 32'h300, 32'hFFFF_FFF8, 1);
    step(); clr();
    chk("bne_flush", if_flush, 1);
    for (int i = 0; i < 3; i++) begin
      chk("bne_hold", {if_redirect_valid, if_redirect_pc}, {1'b1, 32'h2F8});
      step();
    end
    chk("bne_flush_once", if_flush, 0);
    chk("bne_last", {if_redirect_valid, if_redirect_pc}, {1'b1, 32'h2F8});
    if_redirect_ack = 1;
    step();
    if_redirect_ack = 0;
    chk("bne_done", if_redirect_valid, 0);

    // ex_flush in the second REDIRECT cycle, coincident with ack.
    br(3'b000, 3'b001, 32'h400, 32'h10, 1);
    step(); clr();
    step();
    ex_flush = 1; if_redirect_ack = 1;
    step();
    ex_flush = 0; if_redirect_ack = 0;
    chk("exf_valid", if_redirect_valid, 0);
    chk("exf_cnt", {br_cnt, taken_cnt}, {32'd5, 32'd5});

    // ex_flush overriding a decision.
    clr(); id_valid = 1; id_is_jal = 1; id_pc = 32'h500; id_imm = 8; ex_flush = 1;
    step(); clr();
    chk("exf_dec", {if_redirect_valid, if_flush}, 0);
    chk("exf_dec_cnt", taken_cnt, 5);

    // Reset while waiting for operands.
    br(3'b100, 3'b010, 32'h600, 32'h10, 0);
    step();
    chk("wait_stall", id_stall, 1);
    rst_n = 0; clr();
    step();
    rst_n = 1;
    chk("rst_mid", {if_redirect_valid, id_stall}, 0);
    chk("rst_mid_cnt", {br_cnt, taken_cnt}, 0);
    step();

    // Reserved funct3: illegal pulse, counted, not taken.
    br(3'b010, 3'b111, 32'h700, 32'h10, 1);
    step(); clr();
    chk("ill_pulse", illegal_branch, 1);
    chk("ill_noredir", if_redirect_valid, 0);
    chk("ill_cnt", {br_cnt, taken_cnt}, {32'd1, 32'd0});
    step();
    chk("ill_off", illegal_branch, 0);
    step();

    armed = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
